// File: rtl/i2c_pkg.sv
// i2c_pkg -- shared types and constants for the I2C register-access master.
//   state_t        : controller states, one per bus slot type
//   PH0..PH3       : quarter-slot phase encodings (SCL low in PH0/PH1, high in PH2/PH3)
//   DEFAULT_DEV_ID : default target ID
//   i2c_req_t      : transaction captured when start is accepted
package i2c_pkg;

   typedef enum logic [3:0] {
      IDLE, START, ADDR, ACK1, REG, ACK2, WDATA, ACK3, RDATA, MNACK, STOP, DONE
   } state_t;

   localparam logic [1:0] PH0 = 2'd0;
   localparam logic [1:0] PH1 = 2'd1;
   localparam logic [1:0] PH2 = 2'd2;
   localparam logic [1:0] PH3 = 2'd3;

   localparam logic [6:0] DEFAULT_DEV_ID = 7'h05;

   typedef struct packed {
      logic       rw;
      logic [6:0] dev_addr;
      logic [7:0] reg_addr;
      logic [7:0] wdata;
   } i2c_req_t;

endpackage

// File: rtl/i2c_phase_timer.sv
// i2c_phase_timer -- splits a bit slot into four phases of QUARTER clocks.
//   CLK, Reset : clock, async active-low reset
//   clr        : restart at phase 0, count 0 (asserted on every state entry)
//   phase      : current quarter within the slot
//   tick       : last clock of the current quarter
module i2c_phase_timer #(
   parameter int unsigned QUARTER = 31
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       clr,
   output logic [1:0] phase,
   output logic       tick
);

   localparam int unsigned CW = (QUARTER > 1) ? $clog2(QUARTER) : 1;

   logic [CW-1:0] cnt;

   assign tick = (cnt == CW'(QUARTER - 1));

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         cnt   <= '0;
         phase <= 2'd0;
      end else if (clr) begin
         cnt   <= '0;
         phase <= 2'd0;
      end else if (tick) begin
         cnt   <= '0;
         phase <= phase + 2'd1;   // wraps 3 -> 0 into the next slot
      end else begin
         cnt   <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/i2c_master_ctrl.sv
// i2c_master_ctrl -- single-register I2C write/read master (no repeated START).
//   CLK, Reset         : clock, async active-low reset (aborts without STOP)
//   start, rw          : request (sampled in IDLE only), 1 = read
//   dev_addr, reg_addr : target ID and register
//   wdata              : write data
//   iSDA               : sampled SDA line
//   SCL, SDA_oe        : bus clock, open-drain SDA pull-down enable
//   busy, done         : in progress, one-cycle completion pulse
//   ack_err            : sticky NACK flag, cleared when a new start is accepted
//   rdata              : read result, updated only on the 8th data sample
module i2c_master_ctrl
   import i2c_pkg::*;
#(
   parameter int unsigned QUARTER = 31,
   parameter logic [6:0]  DEV_ID  = DEFAULT_DEV_ID
) (
   input  logic       CLK,
   input  logic       Reset,
   input  logic       start,
   input  logic       rw,
   input  logic [6:0] dev_addr,
   input  logic [7:0] reg_addr,
   input  logic [7:0] wdata,
   input  logic       iSDA,
   output logic       SCL,
   output logic       SDA_oe,
   output logic       busy,
   output logic       done,
   output logic       ack_err,
   output logic [7:0] rdata
);

   if (DEV_ID == 7'h00) begin : g_bad_id
      $error("DEV_ID 7'h00 is the general-call address");
   end

   state_t     state_q, state_n;
   i2c_req_t   req_q;
   logic [1:0] phase;
   logic       tick, tmr_clr, slot_end, sample_pt, last_bit, accept;
   logic [2:0] bit_cnt;
   logic [6:0] rx_sh;
   logic [7:0] tx_byte;

   // Held clear in IDLE so START always begins at phase 0, count 0.
   assign tmr_clr   = (state_q == IDLE) || (state_n != state_q);
   assign slot_end  = tick && (phase == PH3);
   assign sample_pt = tick && (phase == PH2);
   assign last_bit  = (bit_cnt == 3'd7);
   assign accept    = (state_q == IDLE) && start;

   i2c_phase_timer #(.QUARTER(QUARTER)) u_timer (
      .CLK   (CLK),
      .Reset (Reset),
      .clr   (tmr_clr),
      .phase (phase),
      .tick  (tick)
   );

   // ---- state register ----
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) state_q <= IDLE;
      else        state_q <= state_n;
   end

   // ---- next state ----
   always_comb begin
      state_n = state_q;
      case (state_q)
         IDLE:  if (start) state_n = START;
         START: if (slot_end) state_n = ADDR;
         ADDR:  if (slot_end && last_bit) state_n = ACK1;
         // ack_err was captured at this slot's sample point
         ACK1:  if (slot_end) state_n = ack_err ? STOP : REG;
         REG:   if (slot_end && last_bit) state_n = ACK2;
         ACK2:  if (slot_end) state_n = ack_err ? STOP : (req_q.rw ? RDATA : WDATA);
         WDATA: if (slot_end && last_bit) state_n = ACK3;
         ACK3:  if (slot_end) state_n = STOP;
         RDATA: if (slot_end && last_bit) state_n = MNACK;
         MNACK: if (slot_end) state_n = STOP;
         STOP:  if (slot_end) state_n = DONE;
         DONE:  state_n = IDLE;
         default: state_n = IDLE;
      endcase
   end

   // ---- bit counter: restarts on every state entry ----
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset)        bit_cnt <= 3'd0;
      else if (tmr_clr)  bit_cnt <= 3'd0;
      else if (slot_end) bit_cnt <= bit_cnt + 3'd1;
   end

   // ---- request latch, ack tracking, read shifter ----
   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         req_q   <= '0;
         ack_err <= 1'b0;
         rx_sh   <= 7'd0;
         rdata   <= 8'h00;
      end else begin
         if (accept) begin
            req_q.rw       <= rw;
            req_q.dev_addr <= dev_addr;
            req_q.reg_addr <= reg_addr;
            req_q.wdata    <= wdata;
            ack_err        <= 1'b0;
         end
         if (sample_pt && (state_q inside {ACK1, ACK2, ACK3}) && iSDA)
            ack_err <= 1'b1;
         if (sample_pt && (state_q == RDATA)) begin
            rx_sh <= {rx_sh[5:0], iSDA};
            if (last_bit) rdata <= {rx_sh, iSDA};
         end
      end
   end

   always_comb begin
      case (state_q)
         ADDR:    tx_byte = {req_q.dev_addr, req_q.rw};
         REG:     tx_byte = req_q.reg_addr;
         default: tx_byte = req_q.wdata;
      endcase
   end

   // ---- outputs ----
   // Data bits only move with bit_cnt/state, i.e. at phase-0 entry while SCL
   // falls; START and STOP are the only slots that move SDA with SCL high.
   always_comb begin
      SCL    = 1'b1;
      SDA_oe = 1'b0;
      busy   = (state_q != IDLE) && (state_q != DONE);
      done   = (state_q == DONE);
      case (state_q)
         START: SDA_oe = phase[1];
         ADDR, REG, WDATA: begin
            SCL    = phase[1];
            SDA_oe = ~tx_byte[~bit_cnt];      // MSB first
         end
         ACK1, ACK2, ACK3, RDATA, MNACK: SCL = phase[1];
         STOP: begin
            SCL    = (phase != PH0);
            SDA_oe = ~phase[1];
         end
         default: ;
      endcase
   end

endmodule

// File: tb/tb_i2c_master_ctrl.sv
module tb_i2c_master_ctrl;

   localparam int          Q    = 31;
   localparam int          SLOT = 4 * Q;
   localparam logic [6:0]  DID  = 7'h05;

   logic       CLK = 1'b0, Reset = 1'b0, start = 1'b0, rw = 1'b0;
   logic [6:0] dev_addr = '0;
   logic [7:0] reg_addr = '0, wdata = '0;
   logic       iSDA, SCL, SDA_oe, busy, done, ack_err;
   logic [7:0] rdata;

   logic       slave_low = 1'b0;
   logic       s_rw = 1'b0, s_nack2 = 1'b0, s_nack3 = 1'b0;
   logic [7:0] s_rdval = '0;

   assign iSDA = ~(SDA_oe | slave_low);

   always #5 CLK = ~CLK;

   i2c_master_ctrl #(.QUARTER(Q), .DEV_ID(DID)) dut (
      .CLK(CLK), .Reset(Reset), .start(start), .rw(rw), .dev_addr(dev_addr),
      .reg_addr(reg_addr), .wdata(wdata), .iSDA(iSDA), .SCL(SCL), .SDA_oe(SDA_oe),
      .busy(busy), .done(done), .ack_err(ack_err), .rdata(rdata)
   );

   typedef struct {
      logic [31:0] bits;     // SDA level at each SCL rise, first rise in bit 0
      int          nbits;
      int          cyc;
      logic [7:0]  rdata;
      logic        ack_err;
   } exp_t;

   exp_t       sb[$];
   int         n_checks = 0, n_fail = 0, ndone = 0;
   logic [7:0] exp_rd = 8'h00;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // Transaction as seen on the wire: bytes MSB first, each followed by its
   // ack bit; a NACK on address or register ends the byte list; the STOP slot
   // adds one SCL rise with SDA still low. START has no SCL rise.
   function automatic exp_t model(input logic r, input logic [6:0] d, input logic [7:0] ra,
                                  input logic [7:0] wd, input logic [7:0] rv,
                                  input logic n2, input logic n3, input logic [7:0] prev_rd);
      exp_t e;
      logic [7:0] bytes [3];
      logic       ackb  [3];
      e.bits = '0; e.nbits = 0; e.ack_err = 1'b0; e.rdata = prev_rd;
      bytes[0] = {d, r};
      bytes[1] = ra;
      bytes[2] = r ? rv : wd;
      ackb[0]  = (d != DID);
      ackb[1]  = n2;
      ackb[2]  = r ? 1'b1 : n3;
      for (int b = 0; b < 3; b++) begin
         for (int i = 7; i >= 0; i--) begin
            e.bits[e.nbits] = bytes[b][i];
            e.nbits++;
         end
         e.bits[e.nbits] = ackb[b];
         e.nbits++;
         if (b == 2) begin
            if (r) e.rdata = rv;
            else if (n3) e.ack_err = 1'b1;
         end else if (ackb[b]) begin
            e.ack_err = 1'b1;
            break;
         end
      end
      e.bits[e.nbits] = 1'b0;
      e.nbits++;
      e.cyc = (e.nbits + 1) * SLOT;
      return e;
   endfunction

   // Slave pull-down for the bit following SCL fall number n after START.
   function automatic logic slave_drive(input int n, input logic [6:0] a);
      if (n == 8)                           return (a == DID);
      if (a != DID)                         return 1'b0;
      if (n == 17)                          return !s_nack2;
      if (s_nack2 && n >= 18)               return 1'b0;
      if (s_rw && n >= 18 && n <= 25)       return !s_rdval[25 - n];
      if (!s_rw && n == 26)                 return !s_nack3;
      return 1'b0;
   endfunction

   // ---- bus monitor / slave / scoreboard checker ----
   initial begin
      logic        p_scl, p_line, p_oe, p_busy, p_done, line, cap, in_txn;
      int          cyc, hi_chg, fall_n, rise_n;
      logic [31:0] bb;
      logic [6:0]  s_addr;
      exp_t        e;
      p_scl = 1'b1; p_line = 1'b1; p_oe = 1'b0; p_busy = 1'b0; p_done = 1'b0;
      cap = 1'b0; in_txn = 1'b0; cyc = 0; hi_chg = 0; fall_n = 0; rise_n = 0;
      bb = '0; s_addr = '0;
      forever begin
         @(negedge CLK);
         line = ~(SDA_oe | slave_low);
         if (!Reset) begin
            cap = 1'b0; in_txn = 1'b0; slave_low = 1'b0;
            p_busy = 1'b0; p_done = 1'b0; p_line = 1'b1;
         end else begin
            if (p_done) chk("done_width", done, 1'b0);
            if (cap && SCL && (SDA_oe != p_oe)) hi_chg++;
            if (p_scl && SCL && p_line && !line) begin
               in_txn = 1'b1; fall_n = 0; rise_n = 0; bb = '0; s_addr = '0;
            end else if (in_txn && !p_scl && SCL) begin
               if (rise_n < 32) bb[rise_n] = line;
               if (rise_n < 7) s_addr = {s_addr[5:0], line};
               rise_n++;
            end else if (in_txn && p_scl && !SCL) begin
               slave_low = slave_drive(fall_n, s_addr);
               fall_n++;
            end
            if (in_txn && p_scl && SCL && !p_line && line) in_txn = 1'b0;
            if (cap) cyc++;
            if (busy && !p_busy) begin
               cap = 1'b1; cyc = 0; hi_chg = 0;
            end
            if (done) begin
               ndone++;
               chk("pending_expect", sb.size(), 1);
               if (sb.size() > 0) begin
                  e = sb.pop_front();
                  chk("scl_rises", rise_n, e.nbits);
                  chk("bus_bits", bb, e.bits);
                  chk("txn_cycles", cyc, e.cyc);
                  chk("rdata", rdata, e.rdata);
                  chk("ack_err", ack_err, e.ack_err);
                  chk("busy_at_done", busy, 1'b0);
                  chk("sda_chg_scl_high", hi_chg, 2);
               end
               cap = 1'b0;
            end
            p_busy = busy; p_done = done; p_line = line;
         end
         p_scl = SCL; p_oe = SDA_oe;
      end
   end

   task automatic issue(input logic r, input logic [6:0] d, input logic [7:0] ra,
                        input logic [7:0] wd, input logic [7:0] rv,
                        input logic n2, input logic n3, input bit push);
      exp_t e;
      s_rw = r; s_rdval = rv; s_nack2 = n2; s_nack3 = n3;
      rw = r; dev_addr = d; reg_addr = ra; wdata = wd; start = 1'b1;
      if (push) begin
         e = model(r, d, ra, wd, rv, n2, n3, exp_rd);
         sb.push_back(e);
         exp_rd = e.rdata;
      end
      @(posedge CLK);
      #1;
      start = 1'b0;
      chk("busy_rise", busy, 1'b1);
      // inputs must not matter once latched
      rw = 1'($urandom); dev_addr = 7'($urandom); reg_addr = 8'($urandom); wdata = 8'($urandom);
   endtask

   task automatic wait_done(input int n0);
      int k = 0;
      while (ndone == n0 && k < 130 * Q) begin
         @(negedge CLK);
         k++;
      end
      if (ndone == n0) chk("done_timeout", ndone, n0 + 1);
      repeat (3) @(negedge CLK);
   endtask

   initial begin
      int         n0;
      logic       r, n2, n3;
      logic [6:0] d;
      repeat (3) @(negedge CLK);
      chk("rst_scl", SCL, 1'b1);
      chk("rst_oe", SDA_oe, 1'b0);
      chk("rst_busy", busy, 1'b0);
      chk("rst_done", done, 1'b0);
      chk("rst_ack_err", ack_err, 1'b0);
      chk("rst_rdata", rdata, 8'h00);
      Reset = 1'b1;
      repeat (2) @(negedge CLK);

      // write to the default ID
      n0 = ndone; issue(1'b0, DID, 8'h4A, 8'h4A, 8'h00, 1'b0, 1'b0, 1'b1); wait_done(n0);
      // read from the default ID
      n0 = ndone; issue(1'b1, DID, 8'hB5, 8'h00, 8'h3C, 1'b0, 1'b0, 1'b1); wait_done(n0);
      // wrong ID: address NACK, rdata keeps 3C
      n0 = ndone; issue(1'b1, 7'h55, 8'h12, 8'h00, 8'hA5, 1'b0, 1'b0, 1'b1); wait_done(n0);

      // start pulsed mid-REG with different inputs is ignored
      n0 = ndone; issue(1'b0, DID, 8'h21, 8'h9C, 8'h00, 1'b0, 1'b0, 1'b1);
      repeat (12 * SLOT) @(negedge CLK);
      rw = 1'b1; dev_addr = 7'h55; reg_addr = 8'hFF; wdata = 8'h00; start = 1'b1;
      @(negedge CLK);
      start = 1'b0;
      chk("busy_hold", busy, 1'b1);
      wait_done(n0);

      // reset during WDATA bit 3 (a 0 bit, so SDA is being pulled low)
      issue(1'b0, DID, 8'h3C, 8'hE0, 8'h00, 1'b0, 1'b0, 1'b0);
      repeat (22 * SLOT + Q) @(negedge CLK);
      chk("pre_reset_oe", SDA_oe, 1'b1);
      Reset = 1'b0;
      #1;
      chk("abort_scl", SCL, 1'b1);
      chk("abort_oe", SDA_oe, 1'b0);
      chk("abort_busy", busy, 1'b0);
      chk("abort_rdata", rdata, 8'h00);
      exp_rd = 8'h00;
      repeat (2) @(negedge CLK);
      Reset = 1'b1;
      n0 = ndone; issue(1'b0, DID, 8'h5A, 8'hC3, 8'h00, 1'b0, 1'b0, 1'b1); wait_done(n0);

      // randomized transactions, occasional wrong ID / NACKs
      for (int t = 0; t < 6; t++) begin
         r  = 1'($urandom);
         d  = ($urandom_range(0, 3) == 0) ? 7'($urandom_range(0, 127)) : DID;
         n2 = ($urandom_range(0, 4) == 0);
         n3 = ($urandom_range(0, 4) == 0);
         n0 = ndone;
         issue(r, d, 8'($urandom), 8'($urandom), 8'($urandom), n2, n3, 1'b1);
         wait_done(n0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
